// File: rtl/e_mdu_pkg.sv
// Shared MD-op encoding for the E-stage multiply/divide unit and its neighbours.
package e_mdu_pkg;

    localparam int MD_OP_LEN = 4;

    typedef enum logic [MD_OP_LEN-1:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } md_op_e;

    function automatic logic is_start_op(input logic [MD_OP_LEN-1:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns HI/LO, result commits after MULT_CYCLES/DIV_CYCLES busy cycles.
// MDStall holds D while an MD op in D would collide with a starting or outstanding operation.
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [MD_OP_LEN-1:0] MDOp,
    input  logic [31:0]          A,
    input  logic [31:0]          B,
    input  logic                 DIsMD,
    output logic                 Start,
    output logic                 Busy,
    output logic                 MDStall,
    output logic [31:0]          HI,
    output logic [31:0]          LO,
    output logic [31:0]          MDOut
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic [31:0]      pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic             pend_wr_q, pend_wr_d;

    logic [63:0]        prod_s, prod_u;
    logic signed [31:0] a_s, b_s, quo_s, rem_s;
    logic [31:0]        b_u, quo_u, rem_u;

    assign Start   = is_start_op(MDOp);
    assign Busy    = (cnt_q != '0);
    assign MDStall = DIsMD && (Start || Busy);
    assign HI      = hi_q;
    assign LO      = lo_q;

    always_comb begin
        MDOut = 32'd0;
        if (MDOp == MD_MFHI)      MDOut = hi_q;
        else if (MDOp == MD_MFLO) MDOut = lo_q;
    end

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Divisor forced to 1 when zero so the divider never sees x; the result is discarded anyway.
    assign a_s   = $signed(A);
    assign b_s   = (B == 32'd0) ? 32'sd1 : $signed(B);
    assign b_u   = (B == 32'd0) ? 32'd1 : B;
    assign quo_s = a_s / b_s;
    assign rem_s = a_s % b_s;
    assign quo_u = A / b_u;
    assign rem_u = A % b_u;

    always_comb begin
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;

        if (Busy) begin
            cnt_d = cnt_q - CNT_W'(1);
            if ((cnt_q == CNT_W'(1)) && pend_wr_q) begin
                hi_d = pend_hi_q;
                lo_d = pend_lo_q;
            end
        end else begin
            case (MDOp)
                MD_MULT: begin
                    {pend_hi_d, pend_lo_d} = prod_s;
                    pend_wr_d = 1'b1;
                    cnt_d     = CNT_W'(MULT_CYCLES);
                end
                MD_MULTU: begin
                    {pend_hi_d, pend_lo_d} = prod_u;
                    pend_wr_d = 1'b1;
                    cnt_d     = CNT_W'(MULT_CYCLES);
                end
                MD_DIV: begin
                    pend_hi_d = rem_s;
                    pend_lo_d = quo_s;
                    pend_wr_d = (B != 32'd0);
                    cnt_d     = CNT_W'(DIV_CYCLES);
                end
                MD_DIVU: begin
                    pend_hi_d = rem_u;
                    pend_lo_d = quo_u;
                    pend_wr_d = (B != 32'd0);
                    cnt_d     = CNT_W'(DIV_CYCLES);
                end
                MD_MTHI: hi_d = A;
                MD_MTLO: lo_d = A;
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q     <= '0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

endmodule
